// File: rtl/rect_extract_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rect_extract_pkg
// Brief   : Shared rectangle-item layout, default geometry and FSM encoding.
// Revision: 1.0 - initial release
// ============================================================================

package rect_extract_pkg;

    localparam int c_RECT_NUMMAX    = 4;
    localparam int c_POSITION_WIDTH = 10;
    localparam int c_OV5640_X       = 640;
    localparam int c_OV5640_Y       = 480;

    // Item layout shared with the overlay consumer
    localparam int c_ITEM_W        = 32;
    localparam int c_FIELD_W       = 8;
    localparam int c_ITEM_XMIN_LSB = 24;
    localparam int c_ITEM_YMIN_LSB = 16;
    localparam int c_ITEM_XMAX_LSB = 8;
    localparam int c_ITEM_YMAX_LSB = 0;

    localparam logic [1:0] c_ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] c_ST_ACCUM    = 2'd1;
    localparam logic [1:0] c_ST_PACK     = 2'd2;

    typedef struct packed {
        logic [c_FIELD_W-1:0] xmin;
        logic [c_FIELD_W-1:0] ymin;
        logic [c_FIELD_W-1:0] xmax;
        logic [c_FIELD_W-1:0] ymax;
    } box_t;

    // 10-bit pixel coordinate to 4-pixel grid (floor)
    function automatic logic [c_FIELD_W-1:0] coarse(input logic [9:0] v);
        return c_FIELD_W'(v >> 2);
    endfunction

    function automatic logic [c_ITEM_W-1:0] pack_item(input box_t b);
        logic [c_ITEM_W-1:0] item;
        item = '0;
        item[c_ITEM_XMIN_LSB +: c_FIELD_W] = b.xmin;
        item[c_ITEM_YMIN_LSB +: c_FIELD_W] = b.ymin;
        item[c_ITEM_XMAX_LSB +: c_FIELD_W] = b.xmax;
        item[c_ITEM_YMAX_LSB +: c_FIELD_W] = b.ymax;
        return item;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rect_extract_acc.sv
`default_nettype none
// ============================================================================
// Module  : rect_acc
// Brief   : One class bounding-box accumulator with saturating hit count and
//           MIN_PIX-gated packed item output.
// Revision: 1.0 - initial release
// ============================================================================

module rect_acc
    import rect_extract_pkg::*;
#(
    parameter int P_W     = c_POSITION_WIDTH,
    parameter int MIN_PIX = 16,
    parameter int CNT_W   = 20
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                i_clear,
    input  logic                i_hit,
    input  logic [P_W-1:0]      i_x,
    input  logic [P_W-1:0]      i_y,
    output logic [c_ITEM_W-1:0] o_item
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_MIN = CNT_W'(MIN_PIX);

    logic [P_W-1:0]   r_xmin;
    logic [P_W-1:0]   r_ymin;
    logic [P_W-1:0]   r_xmax;
    logic [P_W-1:0]   r_ymax;
    logic [CNT_W-1:0] r_cnt;
    box_t             w_box;
    logic             w_enough;

    // Clear together with a hit loads the box with that single pixel
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_xmin <= '1;
            r_ymin <= '1;
            r_xmax <= '0;
            r_ymax <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            if (i_hit) begin
                r_xmin <= i_x;
                r_ymin <= i_y;
                r_xmax <= i_x;
                r_ymax <= i_y;
                r_cnt  <= CNT_W'(1);
            end else begin
                r_xmin <= '1;
                r_ymin <= '1;
                r_xmax <= '0;
                r_ymax <= '0;
                r_cnt  <= '0;
            end
        end else if (i_hit) begin
            if (i_x < r_xmin) r_xmin <= i_x;
            if (i_y < r_ymin) r_ymin <= i_y;
            if (i_x > r_xmax) r_xmax <= i_x;
            if (i_y > r_ymax) r_ymax <= i_y;
            if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_box.xmin = coarse(10'(r_xmin));
        w_box.ymin = coarse(10'(r_ymin));
        w_box.xmax = coarse(10'(r_xmax));
        w_box.ymax = coarse(10'(r_ymax));
    end

    assign w_enough = (r_cnt >= c_CNT_MIN);
    assign o_item   = w_enough ? pack_item(w_box) : '0;

endmodule

`default_nettype wire

// File: rtl/rect_extract.sv
`default_nettype none
// ============================================================================
// Module  : rect_extract
// Brief   : Per-class bounding-box extractor; publishes packed rectangle items
//           for the overlay stage at end of every complete frame.
// Revision: 1.0 - initial release
// ============================================================================

module rect_extract
    import rect_extract_pkg::*;
#(
    parameter int N       = c_RECT_NUMMAX,
    parameter int P_W     = c_POSITION_WIDTH,
    parameter int IMG_X   = c_OV5640_X,
    parameter int IMG_Y   = c_OV5640_Y,
    parameter int MIN_PIX = 16,
    parameter int CNT_W   = 20
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     i_valid,
    input  logic                     i_sof,
    input  logic                     i_hit,
    input  logic [$clog2(N+1)-1:0]   i_class,
    output logic [N*c_ITEM_W-1:0]    o_item,
    output logic                     o_item_valid,
    output logic                     o_frame_err
);

    localparam int             c_CLS_W  = $clog2(N+1);
    localparam logic [P_W-1:0] c_X_LAST = P_W'(IMG_X - 1);
    localparam logic [P_W-1:0] c_Y_LAST = P_W'(IMG_Y - 1);

    logic [P_W-1:0]        r_cnt_x;
    logic [P_W-1:0]        r_cnt_y;
    logic [P_W-1:0]        w_cur_x;
    logic [P_W-1:0]        w_cur_y;
    logic                  w_x_end;
    logic                  w_y_end;
    logic                  w_last;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    logic                  w_accept;
    logic                  w_abort;
    logic                  w_pack;
    logic                  w_clear;
    logic                  w_hit_any;

    logic [N*c_ITEM_W-1:0] w_items;
    logic [N*c_ITEM_W-1:0] r_item;
    logic                  r_item_valid;
    logic                  r_frame_err;

    // Position of the pixel currently presented; a start-of-frame pins it to the origin
    assign w_cur_x = i_sof ? '0 : r_cnt_x;
    assign w_cur_y = i_sof ? '0 : r_cnt_y;
    assign w_x_end = (w_cur_x == c_X_LAST);
    assign w_y_end = (w_cur_y == c_Y_LAST);
    assign w_last  = w_x_end && w_y_end;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_x <= '0;
            r_cnt_y <= '0;
        end else if (i_valid) begin
            if (w_x_end) begin
                r_cnt_x <= '0;
                r_cnt_y <= w_y_end ? '0 : w_cur_y + P_W'(1);
            end else begin
                r_cnt_x <= w_cur_x + P_W'(1);
                r_cnt_y <= w_cur_y;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_ST_WAIT_SOF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_WAIT_SOF,
            c_ST_PACK: begin
                w_state_nxt = (i_valid && i_sof) ? c_ST_ACCUM : c_ST_WAIT_SOF;
            end
            c_ST_ACCUM: begin
                if (i_valid && w_last) begin
                    w_state_nxt = c_ST_PACK;
                end
            end
            default: begin
                w_state_nxt = c_ST_WAIT_SOF;
            end
        endcase
    end

    // Every start-of-frame reloads the accumulators with the first pixel
    always_comb begin
        w_pack    = (r_state == c_ST_PACK);
        w_accept  = i_valid && ((r_state == c_ST_ACCUM) || i_sof);
        w_abort   = (r_state == c_ST_ACCUM) && i_valid && i_sof &&
                    ((r_cnt_x != '0) || (r_cnt_y != '0));
        w_clear   = w_pack || (i_valid && i_sof);
        w_hit_any = w_accept && i_hit;
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_acc
        localparam logic [c_CLS_W-1:0] c_IDX = c_CLS_W'(gi);

        rect_acc #(
            .P_W     (P_W),
            .MIN_PIX (MIN_PIX),
            .CNT_W   (CNT_W)
        ) u_acc (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .i_clear   (w_clear),
            .i_hit     (w_hit_any && (i_class == c_IDX)),
            .i_x       (w_cur_x),
            .i_y       (w_cur_y),
            .o_item    (w_items[gi*c_ITEM_W +: c_ITEM_W])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_item       <= '0;
            r_item_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_pack) begin
                r_item <= w_items;
            end
            r_item_valid <= w_pack;
            r_frame_err  <= w_abort;
        end
    end

    assign o_item       = r_item;
    assign o_item_valid = r_item_valid;
    assign o_frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_rect_extract.sv
`default_nettype none
// ============================================================================
// Module  : tb_rect_extract
// Brief   : Directed scoreboard bench for rect_extract on a 16x8 image.
// Revision: 1.0 - initial release
// ============================================================================

module tb_rect_extract;

    localparam int N     = 4;
    localparam int IMG_X = 16;
    localparam int IMG_Y = 8;
    localparam int NPIX  = IMG_X * IMG_Y;
    localparam int CW    = 3;

    localparam logic [127:0] c_EXP_BOX0 = {96'd0, 32'h0100_0201};
    localparam logic [127:0] c_EXP_CLS3 = {32'h0000_0301, 96'd0};

    logic            sys_clk   = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic            i_valid   = 1'b0;
    logic            i_sof     = 1'b0;
    logic            i_hit     = 1'b0;
    logic [CW-1:0]   i_class   = '0;
    logic [N*32-1:0] o_item;
    logic            o_item_valid;
    logic            o_frame_err;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int n_vld   = 0;
    int n_err   = 0;
    int v0;
    int e0;

    logic [127:0] exp_q[$];
    int           exp_cyc_q[$];

    rect_extract #(
        .N       (N),
        .P_W     (10),
        .IMG_X   (IMG_X),
        .IMG_Y   (IMG_Y),
        .MIN_PIX (16),
        .CNT_W   (20)
    ) u_dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .i_valid      (i_valid),
        .i_sof        (i_sof),
        .i_hit        (i_hit),
        .i_class      (i_class),
        .o_item       (o_item),
        .o_item_valid (o_item_valid),
        .o_frame_err  (o_frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard: every item pulse pops one expected item and its due cycle
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (o_frame_err) n_err++;
            if (o_item_valid) begin
                n_vld++;
                if (exp_q.size() == 0) begin
                    check("spurious_item_valid", 128'(exp_q.size()), 128'd1);
                end else begin
                    check("item", o_item, exp_q.pop_front());
                    check("item_latency", 128'(cyc), 128'(exp_cyc_q.pop_front()));
                end
            end
        end
    end

    function automatic void pat(input int mode, input int x, input int y,
                                output logic hit, output logic [CW-1:0] cls);
        hit = 1'b0;
        cls = CW'($urandom_range(0, 3));
        case (mode)
            1: if (x >= 4 && x <= 11 && y >= 2 && y <= 5) begin hit = 1'b1; cls = 3'd0; end
            2: begin hit = 1'b1; cls = (y == 4 && x >= 8 && x <= 10) ? 3'd1 : 3'd3; end
            3: begin hit = 1'b1; cls = 3'd4; end
            4: if (x <= 3 && y <= 3) begin hit = 1'b1; cls = 3'd0; end
            default: hit = 1'b0;
        endcase
    endfunction

    task automatic pix(input logic sof, input logic hit, input logic [CW-1:0] cls);
        @(posedge sys_clk);
        #1;
        i_valid = 1'b1;
        i_sof   = sof;
        i_hit   = hit;
        i_class = cls;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            i_valid = 1'b0;
            i_sof   = 1'b0;
            i_hit   = 1'b0;
        end
    endtask

    task automatic frame(input int mode, input bit gaps, input int npix,
                         input logic [127:0] exp, input bit expect_item);
        for (int p = 0; p < npix; p++) begin
            logic          h;
            logic [CW-1:0] c;
            pat(mode, p % IMG_X, p / IMG_X, h, c);
            if (gaps && p != 0 && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
            pix(p == 0, h, c);
        end
        if (expect_item) begin
            exp_q.push_back(exp);
            exp_cyc_q.push_back(cyc + 2);
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("reset_item", o_item, 128'd0);
        check("reset_item_valid", 128'(o_item_valid), 128'd0);
        check("reset_frame_err", 128'(o_frame_err), 128'd0);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        // Free-running pixels without start-of-frame are ignored
        for (int p = 0; p < 200; p++) pix(1'b0, 1'($urandom_range(0, 1)), CW'($urandom_range(0, 3)));
        idle(5);
        check("nosof_item_valid_count", 128'(n_vld), 128'd0);
        check("nosof_frame_err_count", 128'(n_err), 128'd0);
        check("nosof_item", o_item, 128'd0);

        // Class0 box
        frame(1, 1'b0, NPIX, c_EXP_BOX0, 1'b1);
        idle(5);
        check("box0_pending", 128'(exp_q.size()), 128'd0);
        check("box0_valid_count", 128'(n_vld), 128'd1);

        // Sparse class1 below MIN_PIX, class3 covers the frame
        frame(2, 1'b0, NPIX, c_EXP_CLS3, 1'b1);
        idle(5);

        // Out-of-range class, then class0 box with random strobe gaps
        frame(3, 1'b0, NPIX, 128'd0, 1'b1);
        idle(5);
        frame(1, 1'b1, NPIX, c_EXP_BOX0, 1'b1);
        idle(5);
        check("gaps_pending", 128'(exp_q.size()), 128'd0);

        // Short frame aborted by an early start-of-frame
        v0 = n_vld;
        e0 = n_err;
        frame(2, 1'b0, 50, 128'd0, 1'b0);
        frame(1, 1'b0, NPIX, c_EXP_BOX0, 1'b1);
        idle(5);
        check("abort_frame_err_count", 128'(n_err), 128'(e0 + 1));
        check("abort_valid_count", 128'(n_vld), 128'(v0 + 1));

        // Back-to-back frames through the pack cycle
        frame(1, 1'b0, NPIX, c_EXP_BOX0, 1'b1);
        frame(4, 1'b0, NPIX, 128'd0, 1'b1);
        frame(1, 1'b0, NPIX, c_EXP_BOX0, 1'b1);
        idle(5);
        check("b2b_pending", 128'(exp_q.size()), 128'd0);
        check("b2b_item_held", o_item, c_EXP_BOX0);

        // Asynchronous reset mid-frame
        frame(2, 1'b0, 60, 128'd0, 1'b0);
        #3;
        sys_rst_n = 1'b0;
        i_valid   = 1'b0;
        i_sof     = 1'b0;
        #1;
        check("midreset_item", o_item, 128'd0);
        check("midreset_item_valid", 128'(o_item_valid), 128'd0);
        idle(2);
        #2 sys_rst_n = 1'b1;
        frame(2, 1'b0, NPIX, c_EXP_CLS3, 1'b1);
        idle(5);
        check("final_pending", 128'(exp_q.size()), 128'd0);
        check("final_valid_count", 128'(n_vld), 128'd9);
        check("final_frame_err_count", 128'(n_err), 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
